// File: rtl/bus_cycle_controller.sv
// 68030 bus-cycle terminator: per-region wait states, DSACK port-size codes,
// internal or external acknowledge, bus-timeout BERR watchdog and CPU clock divider.
module bus_cycle_controller #(
  parameter int                     NUM_REGIONS    = 4,
  parameter int                     WAIT_WIDTH     = 4,
  parameter int                     SYNC_STAGES    = 2,
  parameter int                     TIMEOUT_CYCLES = 256,
  parameter logic [NUM_REGIONS-1:0] EXTERNAL_MASK  = 4'b1000,
  parameter int                     CPU_CLOCK_DIV  = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            cpu_clock,
  input  logic                            cpu_as,
  input  logic                            cpu_ds,
  input  logic [2:0]                      cpu_fc,
  input  logic [NUM_REGIONS-1:0]          region_select,
  input  logic [NUM_REGIONS*WAIT_WIDTH-1:0] region_wait,
  input  logic [NUM_REGIONS*2-1:0]        region_dsack,
  input  logic [NUM_REGIONS-1:0]          ext_ack,
  output logic [1:0]                      cpu_dsack,
  output logic                            cpu_berr,
  output logic                            cycle_active,
  output logic                            timeout_flag
);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int HALF = CPU_CLOCK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BERR, ST_CPU_SPACE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  as_sync, ds_sync;
  logic [NUM_REGIONS-1:0]  ext_sync [SYNC_STAGES];
  logic                    as_s, ds_s;
  logic [NUM_REGIONS-1:0]  ext_s;
  logic [RW-1:0]           region_reg, sel_idx, cur_idx;
  logic                    none_reg, sel_none, cur_none;
  logic [WAIT_WIDTH-1:0]   wait_cnt, cur_cfg_wait, cur_wait, wait_next;
  logic [TW-1:0]           timeout_cnt, to_next;
  logic [1:0]              cur_code;
  logic                    cur_ext, cur_ext_s, done, timed_out;
  logic [DW-1:0]           div_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      as_sync     <= '1;
      ds_sync     <= '1;
      ext_sync[0] <= '1;
    end else begin
      as_sync     <= {as_sync[SYNC_STAGES-2:0], cpu_as};
      ds_sync     <= {ds_sync[SYNC_STAGES-2:0], cpu_ds};
      ext_sync[0] <= ext_ack;
    end
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_ext_sync
    always_ff @(posedge clock) begin
      if (reset) ext_sync[gi] <= '1;
      else       ext_sync[gi] <= ext_sync[gi-1];
    end
  end

  assign as_s  = as_sync[SYNC_STAGES-1];
  assign ds_s  = ds_sync[SYNC_STAGES-1];
  assign ext_s = ext_sync[SYNC_STAGES-1];

  // The IDLE->WAIT edge counts as the first wait clock, so wait=0 acks on entry.
  always_comb begin
    sel_idx  = '0;
    sel_none = 1'b1;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (!region_select[i]) begin
        sel_idx  = RW'(i);
        sel_none = 1'b0;
      end
    end
    cur_idx      = (state == ST_IDLE) ? sel_idx : region_reg;
    cur_none     = (state == ST_IDLE) ? sel_none : none_reg;
    cur_cfg_wait = '0;
    cur_code     = 2'b11;
    cur_ext      = 1'b0;
    cur_ext_s    = 1'b1;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (RW'(i) == cur_idx) begin
        cur_cfg_wait = region_wait[i*WAIT_WIDTH +: WAIT_WIDTH];
        cur_code     = region_dsack[2*i +: 2];
        cur_ext      = EXTERNAL_MASK[i];
        cur_ext_s    = ext_s[i];
      end
    end
    cur_wait  = (state == ST_IDLE) ? cur_cfg_wait : wait_cnt;
    wait_next = (cur_wait == '0) ? '0 : cur_wait - 1'b1;
    done      = !cur_none && !ds_s && (cur_ext ? !cur_ext_s : (cur_wait == '0));
    to_next   = (timeout_cnt == TW'(TIMEOUT_CYCLES)) ? timeout_cnt : timeout_cnt + 1'b1;
    timed_out = (to_next >= TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      region_reg   <= '0;
      none_reg     <= 1'b0;
      wait_cnt     <= '0;
      timeout_cnt  <= '0;
      cpu_dsack    <= 2'b11;
      cpu_berr     <= 1'b1;
      cycle_active <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (!as_s) begin
          cycle_active <= 1'b1;
          if (cpu_fc == 3'b111) begin
            state <= ST_CPU_SPACE;
          end else begin
            region_reg  <= sel_idx;
            none_reg    <= sel_none;
            wait_cnt    <= wait_next;
            timeout_cnt <= '0;
            if (done) begin
              state     <= ST_ACK;
              cpu_dsack <= cur_code;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt    <= wait_next;
          timeout_cnt <= to_next;
          if (as_s) begin
            state        <= ST_IDLE;
            cycle_active <= 1'b0;
          end else if (done) begin
            state     <= ST_ACK;
            cpu_dsack <= cur_code;
          end else if (timed_out) begin
            state        <= ST_BERR;
            cpu_berr     <= 1'b0;
            timeout_flag <= 1'b1;
          end
        end
        ST_ACK: if (as_s) begin
          state        <= ST_IDLE;
          cpu_dsack    <= 2'b11;
          cycle_active <= 1'b0;
        end
        ST_BERR: if (as_s) begin
          state        <= ST_IDLE;
          cpu_berr     <= 1'b1;
          cycle_active <= 1'b0;
        end
        ST_CPU_SPACE: if (as_s) begin
          state        <= ST_IDLE;
          cycle_active <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      cpu_clock <= 1'b0;
    end else if (div_cnt == DW'(HALF - 1)) begin
      div_cnt   <= '0;
      cpu_clock <= ~cpu_clock;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule
